// File: rtl/tile_queue_pkg.sv
// Shared types and width helpers for the tile input queue.
//   state_e   : streaming FSM states.
//   ptr_w     : write-pointer width, counts 0..N*K inclusive.
//   cnt_w     : skew-counter width, counts 0..K+N-2.
//   idx_w     : flat storage index width, addresses 0..N*K-1.
//   pos_w     : per-channel position width, addresses 0..K-1.
package tile_queue_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  function automatic int ptr_w(input int n, input int k);
    return $clog2(n * k + 1);
  endfunction

  function automatic int cnt_w(input int n, input int k);
    return (k + n > 1) ? $clog2(k + n) : 1;
  endfunction

  function automatic int idx_w(input int n, input int k);
    return (n * k > 1) ? $clog2(n * k) : 1;
  endfunction

  function automatic int pos_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/tile_queue_bank.sv
// One tile of operand storage: N*K words of DATA_WIDTH, channel-major
// (word p holds channel p/K, position p%K). Contents are not reset.
// Ports:
//   clk_i         clock
//   write_en_i    store write_data_i at write_addr_i on the rising edge
//   write_addr_i  flat word index p
//   write_data_i  word to store
//   read_pos_i    per-channel position to read (combinational)
//   read_data_o   per-channel word at that position
module tile_queue_bank
  import tile_queue_pkg::*;
#(
  parameter int N          = 8,
  parameter int K          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = idx_w(N, K),
  parameter int QW         = pos_w(K)
) (
  input  logic                  clk_i,
  input  logic                  write_en_i,
  input  logic [AW-1:0]         write_addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic [QW-1:0]         read_pos_i  [0:N-1],
  output logic [DATA_WIDTH-1:0] read_data_o [0:N-1]
);

  logic [DATA_WIDTH-1:0] mem [0:N*K-1];

  always_ff @(posedge clk_i) begin
    if (write_en_i) mem[write_addr_i] <= write_data_i;
  end

  always_comb begin
    for (int c = 0; c < N; c++) begin
      read_data_o[c] = mem[AW'(c * K) + AW'(read_pos_i[c])];
    end
  end

endmodule

// File: rtl/tile_input_queue.sv
// Edge input queue for the systolic mesh: loads an N-channel x K-deep tile
// over a single-word write port and streams it out with diagonal skew
// (channel c delayed by c cycles).
// Build option: define TILE_INPUT_QUEUE_PING_PONG_EN for two banks, so a
// new tile can be written while the other bank streams.
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   write_valid_i/ready_o/data_i   write handshake and word
//   write_reset_i        clear write pointer / full flag of the write bank
//   start_i              start streaming a full bank (IDLE only)
//   stall_i              freeze streaming
//   data_o/valid_o/last_o  per-channel skewed stream
//   busy_o, done_o       streaming status, one-cycle completion pulse
//   bank_full_o          write bank holds N*K words
//   queue_empty_o        idle with no full bank to stream
// Handshake: a write word transfers on a rising edge where write_valid_i and
// write_ready_o are both high; write_ready_o never depends on write_valid_i.
module tile_input_queue
  import tile_queue_pkg::*;
#(
  parameter int N          = 8,
  parameter int K          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  write_valid_i,
  output logic                  write_ready_o,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  write_reset_i,
  input  logic                  start_i,
  input  logic                  stall_i,
  output logic [DATA_WIDTH-1:0] data_o [0:N-1],
  output logic [N-1:0]          valid_o,
  output logic [N-1:0]          last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  bank_full_o,
  output logic                  queue_empty_o
);

  localparam int PW = ptr_w(N, K);
  localparam int CW = cnt_w(N, K);
  localparam int AW = idx_w(N, K);
  localparam int QW = pos_w(K);
  localparam logic [PW-1:0] FULL_PTR = PW'(N * K);
  localparam logic [CW-1:0] T_LAST   = CW'(K + N - 2);

  state_e                state;
  logic [CW-1:0]         t;
  logic [QW-1:0]         rd_pos  [0:N-1];
  logic [DATA_WIDTH-1:0] rd_data [0:N-1];
  logic [N-1:0]          in_win;
  logic [N-1:0]          at_end;
  logic                  rd_avail;
  logic                  start_ok;

  assign start_ok      = (state == IDLE) && start_i && rd_avail;
  assign queue_empty_o = !rd_avail && (state == IDLE);

  // Skew window: channel c carries element t-c while c <= t < c+K.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      in_win[c] = 1'b0;
      at_end[c] = 1'b0;
      rd_pos[c] = '0;
      if (int'(t) >= c && int'(t) < c + K) begin
        in_win[c] = 1'b1;
        at_end[c] = (int'(t) - c == K - 1);
        rd_pos[c] = QW'(int'(t) - c);
      end
    end
  end

`ifdef TILE_INPUT_QUEUE_PING_PONG_EN
  logic                  rsel;
  logic                  wsel;
  logic [PW-1:0]         ptr [0:1];
  logic [1:0]            full;
  logic                  swap;
  logic                  clr;
  logic                  we;
  logic [DATA_WIDTH-1:0] rd_data0 [0:N-1];
  logic [DATA_WIDTH-1:0] rd_data1 [0:N-1];

  assign wsel          = ~rsel;
  assign full[0]       = (ptr[0] == FULL_PTR);
  assign full[1]       = (ptr[1] == FULL_PTR);
  assign rd_avail      = |full;
  assign bank_full_o   = full[wsel];
  assign write_ready_o = !full[wsel];
  // A start that takes over the write bank must not also see it cleared.
  assign swap          = start_ok && full[wsel];
  assign clr           = write_reset_i && !swap;
  assign we            = write_valid_i && write_ready_o && !clr;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsel   <= 1'b0;
      ptr[0] <= '0;
      ptr[1] <= '0;
    end else begin
      if (swap) rsel <= wsel;
      for (int b = 0; b < 2; b++) begin
        if (state == DONE && rsel == 1'(b)) ptr[b] <= '0;
        else if (clr && wsel == 1'(b))      ptr[b] <= '0;
        else if (we && wsel == 1'(b))       ptr[b] <= ptr[b] + PW'(1);
      end
    end
  end

  tile_queue_bank #(.N(N), .K(K), .DATA_WIDTH(DATA_WIDTH), .AW(AW), .QW(QW)) u_bank0 (
    .clk_i        (clk_i),
    .write_en_i   (we && !wsel),
    .write_addr_i (ptr[0][AW-1:0]),
    .write_data_i (write_data_i),
    .read_pos_i   (rd_pos),
    .read_data_o  (rd_data0)
  );

  tile_queue_bank #(.N(N), .K(K), .DATA_WIDTH(DATA_WIDTH), .AW(AW), .QW(QW)) u_bank1 (
    .clk_i        (clk_i),
    .write_en_i   (we && wsel),
    .write_addr_i (ptr[1][AW-1:0]),
    .write_data_i (write_data_i),
    .read_pos_i   (rd_pos),
    .read_data_o  (rd_data1)
  );

  always_comb begin
    for (int c = 0; c < N; c++) rd_data[c] = rsel ? rd_data1[c] : rd_data0[c];
  end
`else
  logic [PW-1:0] wr_ptr;
  logic          wr_full;
  logic          locked;
  logic          clr;
  logic          we;

  assign wr_full       = (wr_ptr == FULL_PTR);
  assign rd_avail      = wr_full;
  assign bank_full_o   = wr_full;
  // The only bank is being read from STREAM until done_o; keep it frozen.
  assign locked        = (state == STREAM) || busy_o;
  assign write_ready_o = !wr_full && !locked;
  assign clr           = write_reset_i && !locked;
  assign we            = write_valid_i && write_ready_o && !clr;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                    wr_ptr <= '0;
    else if (clr || state == DONE)  wr_ptr <= '0;
    else if (we)                    wr_ptr <= wr_ptr + PW'(1);
  end

  tile_queue_bank #(.N(N), .K(K), .DATA_WIDTH(DATA_WIDTH), .AW(AW), .QW(QW)) u_bank (
    .clk_i        (clk_i),
    .write_en_i   (we),
    .write_addr_i (wr_ptr[AW-1:0]),
    .write_data_i (write_data_i),
    .read_pos_i   (rd_pos),
    .read_data_o  (rd_data)
  );
`endif

  // FSM with registered outputs. busy_o/done_o are the state delayed one
  // cycle so they line up with the registered stream: busy_o covers the
  // cycles carrying data, done_o follows the final element.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      t       <= '0;
      valid_o <= '0;
      last_o  <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      for (int c = 0; c < N; c++) data_o[c] <= '0;
    end else begin
      busy_o  <= (state == STREAM);
      done_o  <= (state == DONE);
      valid_o <= '0;
      last_o  <= '0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= STREAM;
            t     <= '0;
          end
        end
        STREAM: begin
          // While stalled, t and data_o hold; valid/last drop to 0.
          if (!stall_i) begin
            valid_o <= in_win;
            last_o  <= at_end;
            for (int c = 0; c < N; c++) data_o[c] <= in_win[c] ? rd_data[c] : '0;
            if (t == T_LAST) state <= DONE;
            else             t     <= t + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          t     <= '0;
          for (int c = 0; c < N; c++) data_o[c] <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_input_queue.sv
module tb_tile_input_queue;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 32;
  localparam int EW = 2 + 1 + DW;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          write_valid = 1'b0;
  logic          write_reset = 1'b0;
  logic          start       = 1'b0;
  logic          stall       = 1'b0;
  logic [DW-1:0] write_data  = '0;
  logic          write_ready;
  logic [DW-1:0] data_o [0:N-1];
  logic [N-1:0]  valid_o;
  logic [N-1:0]  last_o;
  logic          busy_o;
  logic          done_o;
  logic          bank_full_o;
  logic          queue_empty_o;

  int errors = 0;
  int checks = 0;

  // expected stream entries: {channel, last, data}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_act;
  logic [DW-1:0] d_or;

  tile_input_queue #(.N(N), .K(K), .DATA_WIDTH(DW)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .write_valid_i (write_valid),
    .write_ready_o (write_ready),
    .write_data_i  (write_data),
    .write_reset_i (write_reset),
    .start_i       (start),
    .stall_i       (stall),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .last_o        (last_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .bank_full_o   (bank_full_o),
    .queue_empty_o (queue_empty_o)
  );

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      checks++;
      if ((last_o & ~valid_o) != '0) begin
        errors++;
        $display("FAIL last_without_valid: last=%b valid=%b, required no last without valid",
                 last_o, valid_o);
      end
      for (int c = 0; c < N; c++) begin
        if (valid_o[c]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: ch%0d data=%0d, required no output", c, data_o[c]);
          end else begin
            mon_exp = exp_q.pop_front();
            mon_act = {2'(c), last_o[c], data_o[c]};
            if (mon_act !== mon_exp) begin
              errors++;
              $display("FAIL stream_element: got ch%0d last=%0b data=%0d, required ch%0d last=%0b data=%0d",
                       mon_act[EW-1 -: 2], mon_act[DW], mon_act[DW-1:0],
                       mon_exp[EW-1 -: 2], mon_exp[DW], mon_exp[DW-1:0]);
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic write_words(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      write_valid = 1'b1;
      write_data  = DW'(base + i);
      tick();
    end
    write_valid = 1'b0;
  endtask

  // Expected skewed stream of tile word p = base + p, in monitor order.
  task automatic push_tile(input int base);
    for (int t = 0; t <= K + N - 2; t++) begin
      for (int c = 0; c < N; c++) begin
        if (t >= c && t < c + K) exp_q.push_back({2'(c), 1'(t - c == K - 1), DW'(base + c * K + t - c)});
      end
    end
  endtask

  // Start a full tile; stall covers output cycles stall_at and stall_at+1
  // (0 = no stall). done_cyc is the cycle done_o must pulse.
  task automatic run_stream(input int base, input int stall_at, input int done_cyc);
    push_tile(base);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      stall = (stall_at > 0) && (cyc == stall_at || cyc == stall_at + 1);
      tick();
      chk("busy", DW'(busy_o), DW'(cyc < done_cyc));
      chk("done", DW'(done_o), DW'(cyc == done_cyc));
      if (stall) begin
        chk("stall_valid", DW'(valid_o), 0);
        chk("stall_hold_ch0", data_o[0], DW'(base + stall_at - 2));
      end
      if (cyc == 2) chk("ready_while_busy", DW'(write_ready), 0);
    end
    stall = 1'b0;
    chk("ready_after_done", DW'(write_ready), 1);
    chk("empty_after_done", DW'(queue_empty_o), 1);
  endtask

  initial begin
    // 1: reset values
    repeat (3) tick();
    d_or = '0;
    for (int c = 0; c < N; c++) d_or |= data_o[c];
    chk("reset_data", d_or, 0);
    chk("reset_valid", DW'(valid_o), 0);
    chk("reset_last", DW'(last_o), 0);
    chk("reset_busy", DW'(busy_o), 0);
    chk("reset_done", DW'(done_o), 0);
    chk("reset_full", DW'(bank_full_o), 0);
    chk("reset_empty", DW'(queue_empty_o), 1);
    chk("reset_ready", DW'(write_ready), 1);
    rstn = 1'b1;
    tick();

    // 2: plain stream of words 0..15
    write_words(0, 16);
    chk("full_after_16", DW'(bank_full_o), 1);
    chk("ready_after_16", DW'(write_ready), 0);
    chk("not_empty_when_full", DW'(queue_empty_o), 0);
    run_stream(0, 0, 8);

    // 3: stall in cycles 3-4
    write_words(100, 16);
    run_stream(100, 3, 10);

    // 4: 17th word dropped
    write_words(200, 15);
    chk("full_after_15", DW'(bank_full_o), 0);
    chk("ready_after_15", DW'(write_ready), 1);
    write_words(215, 1);
    chk("full_after_16b", DW'(bank_full_o), 1);
    write_words(999, 1);
    chk("full_after_17", DW'(bank_full_o), 1);
    chk("ready_after_17", DW'(write_ready), 0);
    run_stream(200, 0, 8);

    // 5: partial tile, start ignored, then write_reset
    write_words(300, 10);
    chk("partial_full", DW'(bank_full_o), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      tick();
      chk("partial_busy", DW'(busy_o), 0);
    end
    chk("partial_empty", DW'(queue_empty_o), 1);
    write_reset = 1'b1;
    tick();
    write_reset = 1'b0;
    chk("wreset_full", DW'(bank_full_o), 0);
    chk("wreset_empty", DW'(queue_empty_o), 1);
    chk("wreset_ready", DW'(write_ready), 1);
    write_words(400, 15);
    chk("wreset_ptr_15", DW'(bank_full_o), 0);
    write_words(415, 1);
    chk("wreset_ptr_16", DW'(bank_full_o), 1);

    // 6: async reset in cycle 3 of a stream
    push_tile(400);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #1;
    exp_q.delete();
    rstn = 1'b0;
    #1;
    chk("arst_valid", DW'(valid_o), 0);
    chk("arst_busy", DW'(busy_o), 0);
    chk("arst_data0", data_o[0], 0);
    chk("arst_full", DW'(bank_full_o), 0);
    chk("arst_empty", DW'(queue_empty_o), 1);
    chk("arst_ready", DW'(write_ready), 1);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) begin
      tick();
      chk("post_arst_busy", DW'(busy_o), 0);
      chk("post_arst_valid", DW'(valid_o), 0);
    end

    chk("exp_q_drained", DW'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
